// File: rtl/typed_ndata_unpacker_if.sv
// Byte-stream in / element-stream out bundle for typed_ndata_unpacker.
// Element type is 1 bit: 0 = 32-bit elements, 1 = 64-bit elements.
interface typed_ndata_unpacker_if #(
  parameter int DATABEAT_SIZE = 64,
  parameter int NUM_ELEMENTS  = 8
);
  logic [8*DATABEAT_SIZE-1:0] in_data;
  logic [DATABEAT_SIZE-1:0]   in_keep;
  logic                       in_last;
  logic                       in_typ;
  logic                       in_valid;
  logic                       in_ready;
  logic [64*NUM_ELEMENTS-1:0] out_data;
  logic [NUM_ELEMENTS-1:0]    out_keep;
  logic                       out_last;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_type;
  logic                       err;

  modport slave (
    input  in_data, in_keep, in_last, in_typ, in_valid, out_ready,
    output in_ready, out_data, out_keep, out_last, out_valid, out_type, err
  );
  modport master (
    output in_data, in_keep, in_last, in_typ, in_valid, out_ready,
    input  in_ready, out_data, out_keep, out_last, out_valid, out_type, err
  );
endinterface

// File: rtl/typed_ndata_unpacker.sv
// Compacts a typed byte stream into 32/64-bit element beats via a 2*DB byte buffer.
// Optional protocol checking (keep gaps, dropped remainders) under `TYPED_UNPACK_CHECK_EN.
module typed_ndata_unpacker_lane #(
  parameter int LANE = 0,
  parameter int FW   = 8
) (
  input  logic [63:0]   i_w64,
  input  logic [31:0]   i_w32,
  input  logic          i_wide,
  input  logic [FW-1:0] i_fill,
  output logic [63:0]   o_data,
  output logic          o_keep
);
  localparam logic [FW:0] K8 = (FW+1)'((LANE+1)*8);
  localparam logic [FW:0] K4 = (FW+1)'((LANE+1)*4);

  assign o_data = i_wide ? i_w64 : {32'h0, i_w32};
  assign o_keep = i_wide ? (K8 <= {1'b0, i_fill}) : (K4 <= {1'b0, i_fill});
endmodule

module typed_ndata_unpacker #(
  parameter int DATABEAT_SIZE = 64,
  parameter int NUM_ELEMENTS  = 8
) (
  input  logic clk,
  input  logic rst,
  typed_ndata_unpacker_if.slave bus
);
  localparam int DB = DATABEAT_SIZE;
  localparam int NE = NUM_ELEMENTS;
  localparam int BW = 16*DB;
  localparam int FW = $clog2(2*DB+1);
  localparam int SW = FW+3;

  typedef logic type_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  function automatic int get_type_width(input type_t t);
    return t ? 64 : 32;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_buf, w_buf_nxt;
  logic [FW-1:0] r_fill, w_fill_nxt;
  type_t         r_type;

  logic            w_wide, w_acc, w_pop_hs;
  logic [FW-1:0]   w_beat_bytes, w_cnt, w_pop, w_base;
  logic [DB-1:0]   w_keep_lo;
  logic [8*DB-1:0] w_in_bytes;
  logic [BW-1:0]   w_in_ext, w_low_mask;
  logic [SW-1:0]   w_pop_sh, w_base_sh;
  logic [64*NE-1:0] w_out_data;
  logic [NE-1:0]    w_out_keep;

  assign w_wide       = (get_type_width(r_type) == 64);
  assign w_beat_bytes = w_wide ? FW'(8*NE) : FW'(4*NE);

  // in.ready depends on registers only, never on out.ready
  assign bus.in_ready  = (r_state != FLUSH) && (r_fill <= FW'(DB));
  assign bus.out_valid = (r_state == FLUSH) || ((r_state == RUN) && (r_fill >= w_beat_bytes));
  assign bus.out_last  = (r_state == FLUSH) && (r_fill <= w_beat_bytes);
  assign bus.out_type  = r_type;
  assign w_acc    = bus.in_valid && bus.in_ready;
  assign w_pop_hs = bus.out_valid && bus.out_ready;

  always_comb begin
    w_cnt = FW'(DB);
    for (int i = DB-1; i >= 0; i--)
      if (!bus.in_keep[i]) w_cnt = FW'(i);
    for (int i = 0; i < DB; i++) begin
      w_keep_lo[i] = (FW'(i) < w_cnt);
      w_in_bytes[i*8 +: 8] = (w_acc && w_keep_lo[i]) ? bus.in_data[i*8 +: 8] : 8'h00;
    end
  end

  // Last beat drains everything, dropping any partial element
  assign w_pop      = !w_pop_hs ? '0 : (bus.out_last ? r_fill : w_beat_bytes);
  assign w_base     = r_fill - w_pop;
  assign w_pop_sh   = {w_pop, 3'b000};
  assign w_base_sh  = {w_base, 3'b000};
  assign w_in_ext   = {{(BW-8*DB){1'b0}}, w_in_bytes};
  assign w_low_mask = ~({BW{1'b1}} << w_base_sh);
  assign w_buf_nxt  = ((r_buf >> w_pop_sh) & w_low_mask) | (w_in_ext << w_base_sh);
  assign w_fill_nxt = w_base + (w_acc ? w_cnt : '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_state_nxt = bus.in_last ? FLUSH : RUN;
      RUN:     if (w_acc && bus.in_last) w_state_nxt = FLUSH;
      FLUSH:   if (w_pop_hs && bus.out_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_fill  <= '0;
      r_buf   <= '0;
      r_type  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
      r_buf   <= w_buf_nxt;
      if (r_state == IDLE && w_acc) r_type <= bus.in_typ;
    end
  end

  for (genvar g = 0; g < NE; g++) begin : g_lane
    typed_ndata_unpacker_lane #(.LANE(g), .FW(FW)) u_lane (
      .i_w64  (r_buf[g*64 +: 64]),
      .i_w32  (r_buf[g*32 +: 32]),
      .i_wide (w_wide),
      .i_fill (r_fill),
      .o_data (w_out_data[g*64 +: 64]),
      .o_keep (w_out_keep[g])
    );
  end
  assign bus.out_data = w_out_data;
  assign bus.out_keep = w_out_keep;

`ifdef TYPED_UNPACK_CHECK_EN
  logic r_err, w_gap, w_rem;
  assign w_gap = |(bus.in_keep & ~w_keep_lo);
  assign w_rem = w_wide ? (|r_fill[2:0]) : (|r_fill[1:0]);
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else if ((w_acc && w_gap) || (w_pop_hs && bus.out_last && w_rem)) r_err <= 1'b1;
  end
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif
endmodule
